// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
// drac_pkg: shared command/op-type encodings and dmem responder FSM state. Rev 1.0
// ============================================================================
package drac_pkg;

  localparam logic [4:0] M_XRD = 5'b00000;
  localparam logic [4:0] M_XWR = 5'b00001;
  localparam logic [4:0] M_XLR = 5'b00110;
  localparam logic [4:0] M_XSC = 5'b00111;

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_D  = 3'd3;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;
  localparam logic [2:0] MEM_WU = 3'd6;

  typedef enum logic [0:0] {
    RESP_IDLE = 1'b0,
    RESP_WAIT = 1'b1
  } resp_state_t;

  // log2 of the access size in bytes; unknown encodings behave as doublewords
  function automatic logic [1:0] access_size_log2(input logic [2:0] op);
    logic [1:0] sz;
    case (op)
      MEM_B, MEM_BU: sz = 2'd0;
      MEM_H, MEM_HU: sz = 2'd1;
      MEM_W, MEM_WU: sz = 2'd2;
      default:       sz = 2'd3;
    endcase
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_responder_if: data-memory request/response bundle between core and memory. Rev 1.0
// ============================================================================
interface dmem_responder_if;

  logic        dmem_req_valid_i;
  logic        dmem_req_ready_o;
  logic [4:0]  dmem_req_cmd_i;
  logic [39:0] dmem_req_addr_i;
  logic [2:0]  dmem_op_type_i;
  logic [63:0] dmem_req_data_i;
  logic [7:0]  dmem_req_tag_i;
  logic        dmem_req_invalidate_lr_i;
  logic        dmem_req_kill_i;
  logic        dmem_lock_i;
  logic        dmem_resp_valid_o;
  logic [63:0] dmem_resp_data_o;
  logic        dmem_resp_nack_o;
  logic        dmem_resp_replay_o;
  logic        dmem_xcpt_ma_ld_o;
  logic        dmem_xcpt_ma_st_o;
  logic        dmem_xcpt_pf_ld_o;
  logic        dmem_xcpt_pf_st_o;

  modport master (
    output dmem_req_valid_i, dmem_req_cmd_i, dmem_req_addr_i, dmem_op_type_i,
           dmem_req_data_i, dmem_req_tag_i, dmem_req_invalidate_lr_i,
           dmem_req_kill_i, dmem_lock_i,
    input  dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_data_o,
           dmem_resp_nack_o, dmem_resp_replay_o, dmem_xcpt_ma_ld_o,
           dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o
  );

  modport slave (
    input  dmem_req_valid_i, dmem_req_cmd_i, dmem_req_addr_i, dmem_op_type_i,
           dmem_req_data_i, dmem_req_tag_i, dmem_req_invalidate_lr_i,
           dmem_req_kill_i, dmem_lock_i,
    output dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_data_o,
           dmem_resp_nack_o, dmem_resp_replay_o, dmem_xcpt_ma_ld_o,
           dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
// dmem_align: load lane extraction/extension and store lane replication/byte mask. Rev 1.0
// ============================================================================
module dmem_align
  import drac_pkg::*;
(
  input  logic [2:0]  op_type,
  input  logic [2:0]  byte_off,
  input  logic [63:0] rword,
  input  logic [63:0] wdata,
  output logic        misaligned,
  output logic [63:0] ldata,
  output logic [63:0] wword,
  output logic [7:0]  bmask
);

  logic [1:0]  size_log2;
  logic [63:0] shifted;

  assign size_log2 = access_size_log2(op_type);
  assign shifted   = rword >> {byte_off, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    wword      = wdata;
    bmask      = 8'hFF;
    case (size_log2)
      2'd0: begin
        wword = {8{wdata[7:0]}};
        bmask = 8'b0000_0001 << byte_off;
      end
      2'd1: begin
        misaligned = byte_off[0];
        wword      = {4{wdata[15:0]}};
        bmask      = 8'b0000_0011 << byte_off;
      end
      2'd2: begin
        misaligned = |byte_off[1:0];
        wword      = {2{wdata[31:0]}};
        bmask      = 8'b0000_1111 << byte_off;
      end
      default: begin
        misaligned = |byte_off;
      end
    endcase
  end

  always_comb begin
    ldata = shifted;
    case (op_type)
      MEM_B:   ldata = {{56{shifted[7]}},  shifted[7:0]};
      MEM_H:   ldata = {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   ldata = {{32{shifted[31]}}, shifted[31:0]};
      MEM_BU:  ldata = {56'd0, shifted[7:0]};
      MEM_HU:  ldata = {48'd0, shifted[15:0]};
      MEM_WU:  ldata = {32'd0, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder: scratchpad-backed responder for the core data-memory port. Rev 1.0
// ============================================================================
module dmem_responder
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [39:0] BASE_ADDR   = 40'h0080000000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  dmem_responder_if.slave dmem
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [40:0] END_ADDR = {1'b0, BASE_ADDR} + (41'(DEPTH_WORDS) << 3);
  localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

  resp_state_t state, state_nxt;

  logic [1:0]       cnt;
  logic             first;
  logic             live;
  logic             sc_fail_q;
  logic [4:0]       cmd_q;
  logic [39:0]      addr_q;
  logic [2:0]       op_q;
  logic [63:0]      data_q;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [63:0]      mem [DEPTH_WORDS];

  logic             ready, accept, s1, kill, invalidate, alive, resp_cycle;
  logic [39:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range, is_load, is_store, unsup, misaligned, ok;
  logic             sc_hit, sc_fail, wr_en;
  logic [63:0]      ldata, wword, resp_data;
  logic [7:0]       bmask;
  logic             resp_valid, nack, ma_ld, ma_st, pf_ld, pf_st;
  logic             unused_bits;

  assign kill       = dmem.dmem_req_kill_i;
  assign invalidate = dmem.dmem_req_invalidate_lr_i;
  assign accept     = dmem.dmem_req_valid_i & ready;
  assign s1         = (state == RESP_WAIT) & first;
  assign resp_cycle = (state == RESP_WAIT) & (cnt == 2'd0);
  // kill is only sampled in the first wait cycle; later cycles use the stored verdict
  assign alive      = s1 ? ~kill : live;

  assign offset   = addr_q - BASE_ADDR;
  assign idx      = offset[IDX_W+2:3];
  assign in_range = (addr_q >= BASE_ADDR) & ({1'b0, addr_q} < END_ADDR);
  assign is_load  = (cmd_q == M_XRD) | (cmd_q == M_XLR);
  assign is_store = (cmd_q == M_XWR) | (cmd_q == M_XSC);
  assign unsup    = ~(is_load | is_store);
  assign ok       = ~unsup & ~misaligned & in_range;

  assign sc_hit  = res_valid & (res_idx == idx) & ~invalidate;
  assign sc_fail = s1 ? ~sc_hit : sc_fail_q;
  assign wr_en   = s1 & ~kill & ok & ((cmd_q == M_XWR) | ((cmd_q == M_XSC) & sc_hit));

  assign unused_bits = ^{dmem.dmem_req_tag_i, dmem.dmem_lock_i, offset[39:IDX_W+3]};

  dmem_align u_align (
    .op_type    (op_q),
    .byte_off   (offset[2:0]),
    .rword      (mem[idx]),
    .wdata      (data_q),
    .misaligned (misaligned),
    .ldata      (ldata),
    .wword      (wword),
    .bmask      (bmask)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= RESP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESP_IDLE: if (accept) state_nxt = RESP_WAIT;
      RESP_WAIT: if (resp_cycle || (s1 && kill)) state_nxt = RESP_IDLE;
      default:   state_nxt = RESP_IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == RESP_IDLE);
    resp_valid = resp_cycle & alive & ok;
    nack       = resp_cycle & alive & unsup;
    ma_ld      = s1 & ~kill & ~unsup & misaligned & is_load;
    ma_st      = s1 & ~kill & ~unsup & misaligned & is_store;
    pf_ld      = s1 & ~kill & ~unsup & ~misaligned & ~in_range & is_load;
    pf_st      = s1 & ~kill & ~unsup & ~misaligned & ~in_range & is_store;
    resp_data  = '0;
    if (resp_valid) begin
      case (cmd_q)
        M_XSC:   resp_data = {63'd0, sc_fail};
        M_XWR:   resp_data = '0;
        default: resp_data = ldata;
      endcase
    end
  end

  assign dmem.dmem_req_ready_o   = ready;
  assign dmem.dmem_resp_valid_o  = resp_valid;
  assign dmem.dmem_resp_data_o   = resp_data;
  assign dmem.dmem_resp_nack_o   = nack;
  assign dmem.dmem_resp_replay_o = nack;
  assign dmem.dmem_xcpt_ma_ld_o  = ma_ld;
  assign dmem.dmem_xcpt_ma_st_o  = ma_st;
  assign dmem.dmem_xcpt_pf_ld_o  = pf_ld;
  assign dmem.dmem_xcpt_pf_st_o  = pf_st;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt       <= 2'd0;
      first     <= 1'b0;
      live      <= 1'b0;
      sc_fail_q <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      data_q    <= '0;
    end else begin
      first <= accept;
      if (accept) begin
        cnt    <= CNT_INIT;
        cmd_q  <= dmem.dmem_req_cmd_i;
        addr_q <= dmem.dmem_req_addr_i;
        op_q   <= dmem.dmem_op_type_i;
        data_q <= dmem.dmem_req_data_i;
      end else if ((state == RESP_WAIT) && (cnt != 2'd0)) begin
        cnt <= cnt - 2'd1;
      end
      if (s1) begin
        live      <= ~kill;
        sc_fail_q <= ~sc_hit;
      end
    end
  end

  // invalidate wins over everything; otherwise only executed LR/SC/stores touch it
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      res_valid <= 1'b0;
      res_idx   <= '0;
    end else if (invalidate) begin
      res_valid <= 1'b0;
    end else if (s1 && !kill && ok) begin
      if (cmd_q == M_XLR) begin
        res_valid <= 1'b1;
        res_idx   <= idx;
      end else if (cmd_q == M_XSC) begin
        res_valid <= 1'b0;
      end else if ((cmd_q == M_XWR) && (res_idx == idx)) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (bmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder: randomized self-checking bench against a byte-level memory model. Rev 1.0
// ============================================================================
module tb_dmem_responder;
  import drac_pkg::*;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [39:0] BASE      = 40'h0080000000;
  localparam int unsigned LAT       = 2;
  localparam int          WIN_WORDS = 32;

  logic clk_i = 1'b0;
  logic rstn_i;
  always #5 clk_i = ~clk_i;

  dmem_responder_if dif ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .dmem   (dif)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [WIN_WORDS*8];
  bit         res_v;
  int         res_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl_now();
    return {dif.dmem_req_ready_o, dif.dmem_resp_valid_o, dif.dmem_resp_nack_o,
            dif.dmem_resp_replay_o, dif.dmem_xcpt_ma_ld_o, dif.dmem_xcpt_ma_st_o,
            dif.dmem_xcpt_pf_ld_o, dif.dmem_xcpt_pf_st_o};
  endfunction

  function automatic int size_bytes(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  task automatic run_req(input logic [4:0] cmd, input logic [39:0] addr, input logic [2:0] op,
                         input logic [63:0] data, input bit kill, input bit inval,
                         output logic [63:0] got);
    longint unsigned a, lo, hi;
    int sz, boff, w;
    bit is_ld, is_st, unsup, ma, pf, ok, sc_ok;
    logic [63:0] exp_data;
    logic signed [63:0] t;
    logic [7:0] exp_ctl;
    a  = 64'(addr);
    lo = 64'(BASE);
    hi = lo + 64'(DEPTH) * 8;
    is_ld = (cmd == M_XRD) || (cmd == M_XLR);
    is_st = (cmd == M_XWR) || (cmd == M_XSC);
    unsup = !(is_ld || is_st);
    sz = size_bytes(op);
    ma = !unsup && ((a % 64'(sz)) != 0);
    pf = !unsup && !ma && ((a < lo) || (a >= hi));
    ok = !unsup && !ma && !pf;
    exp_data = '0;
    sc_ok = 0;
    if (ok && !kill) begin
      boff = int'(a - lo);
      w    = boff / 8;
      if (is_ld) begin
        for (int b = 0; b < sz; b++) exp_data = exp_data | (64'(mb[boff+b]) << (8*b));
        if (sz < 8 && (op == MEM_B || op == MEM_H || op == MEM_W)) begin
          t = exp_data << (64 - 8*sz);
          exp_data = t >>> (64 - 8*sz);
        end
        if (cmd == M_XLR) begin
          res_v = 1;
          res_w = w;
        end
      end else begin
        if (cmd == M_XSC) begin
          sc_ok = res_v && (res_w == w) && !inval;
          exp_data = sc_ok ? 64'd0 : 64'd1;
          res_v = 0;
        end
        if (cmd == M_XWR || sc_ok) begin
          for (int b = 0; b < sz; b++) mb[boff+b] = data[8*b +: 8];
          if (cmd == M_XWR && res_v && res_w == w) res_v = 0;
        end
      end
    end
    if (inval) res_v = 0;

    @(negedge clk_i);
    check("ready_idle", 64'(dif.dmem_req_ready_o), 64'd1);
    dif.dmem_req_valid_i = 1'b1;
    dif.dmem_req_cmd_i   = cmd;
    dif.dmem_req_addr_i  = addr;
    dif.dmem_op_type_i   = op;
    dif.dmem_req_data_i  = data;
    dif.dmem_req_tag_i   = 8'($urandom);
    @(posedge clk_i);
    #1;
    dif.dmem_req_valid_i         = 1'b0;
    dif.dmem_req_kill_i          = kill;
    dif.dmem_req_invalidate_lr_i = inval;
    got = '0;
    for (int j = 1; j <= int'(LAT); j++) begin
      @(negedge clk_i);
      if (kill) begin
        exp_ctl = (j == 1) ? 8'h00 : 8'h80;
      end else begin
        exp_ctl = 8'h00;
        if (j == 1) exp_ctl[3:0] = {ma && is_ld, ma && is_st, pf && is_ld, pf && is_st};
        if (j == int'(LAT)) begin
          exp_ctl[6] = ok;
          exp_ctl[5] = unsup;
          exp_ctl[4] = unsup;
        end
      end
      check($sformatf("ctl_c%0d_cmd%0d", j, cmd), 64'(ctl_now()), 64'(exp_ctl));
      if (!kill && ok && j == int'(LAT)) begin
        got = dif.dmem_resp_data_o;
        check($sformatf("resp_data_cmd%0d", cmd), got, exp_data);
      end
      @(posedge clk_i);
      #1;
      dif.dmem_req_kill_i          = 1'b0;
      dif.dmem_req_invalidate_lr_i = 1'b0;
    end
  endtask

  task automatic pulse_inval();
    @(negedge clk_i);
    dif.dmem_req_invalidate_lr_i = 1'b1;
    @(negedge clk_i);
    dif.dmem_req_invalidate_lr_i = 1'b0;
    res_v = 0;
  endtask

  task automatic reset_mid_load(input logic [39:0] addr);
    @(negedge clk_i);
    dif.dmem_req_valid_i = 1'b1;
    dif.dmem_req_cmd_i   = M_XRD;
    dif.dmem_req_addr_i  = addr;
    dif.dmem_op_type_i   = MEM_D;
    @(posedge clk_i);
    #1;
    dif.dmem_req_valid_i = 1'b0;
    #1;
    rstn_i = 1'b0;
    #1;
    check("rst_mid_ctl", 64'(ctl_now() & 8'h7F), 64'd0);
    check("rst_mid_data", dif.dmem_resp_data_o, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    res_v = 0;
    @(negedge clk_i);
    check("rst_release_ctl", 64'(ctl_now()), 64'h80);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] got;
    logic [39:0] last_lr;
    bit          have_lr;
    rstn_i                       = 1'b0;
    dif.dmem_req_valid_i         = 1'b0;
    dif.dmem_req_cmd_i           = '0;
    dif.dmem_req_addr_i          = '0;
    dif.dmem_op_type_i           = '0;
    dif.dmem_req_data_i          = '0;
    dif.dmem_req_tag_i           = '0;
    dif.dmem_req_invalidate_lr_i = 1'b0;
    dif.dmem_req_kill_i          = 1'b0;
    dif.dmem_lock_i              = 1'b0;
    res_v   = 0;
    res_w   = 0;
    have_lr = 0;
    last_lr = BASE;

    repeat (3) @(negedge clk_i);
    check("reset_ctl", 64'(ctl_now()), 64'h80);
    check("reset_data", dif.dmem_resp_data_o, 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_ctl", 64'(ctl_now()), 64'h80);

    for (int w = 0; w < WIN_WORDS; w++)
      run_req(M_XWR, BASE + 40'(8*w), MEM_D, {$urandom, $urandom}, 0, 0, got);

    run_req(M_XWR, 40'h0080000008, MEM_D, 64'h1122334455667788, 0, 0, got);
    run_req(M_XRD, 40'h0080000008, MEM_D, 64'd0, 0, 0, got);
    check("ld_d_value", got, 64'h1122334455667788);
    run_req(M_XRD, 40'h008000000F, MEM_B, 64'd0, 0, 0, got);
    check("lb_value", got, 64'h0000000000000011);
    run_req(M_XWR, 40'h008000000F, MEM_B, 64'h00000000000000F0, 0, 0, got);
    run_req(M_XRD, 40'h008000000F, MEM_B, 64'd0, 0, 0, got);
    check("lb_sext", got, 64'hFFFFFFFFFFFFFFF0);
    run_req(M_XRD, 40'h008000000F, MEM_BU, 64'd0, 0, 0, got);
    check("lbu_zext", got, 64'h00000000000000F0);

    run_req(M_XRD, 40'h0080000002, MEM_W, 64'd0, 0, 0, got);
    run_req(M_XWR, 40'h007FFFFFF8, MEM_D, 64'hDEADBEEFDEADBEEF, 0, 0, got);

    run_req(M_XLR, 40'h0080000010, MEM_D, 64'd0, 0, 0, got);
    run_req(M_XSC, 40'h0080000010, MEM_D, 64'd5, 0, 0, got);
    check("sc_success", got, 64'd0);
    run_req(M_XRD, 40'h0080000010, MEM_D, 64'd0, 0, 0, got);
    check("sc_written", got, 64'd5);
    run_req(M_XSC, 40'h0080000010, MEM_D, 64'd9, 0, 0, got);
    check("sc_second_fail", got, 64'd1);
    run_req(M_XRD, 40'h0080000010, MEM_D, 64'd0, 0, 0, got);
    check("sc_fail_nowrite", got, 64'd5);
    run_req(M_XLR, 40'h0080000010, MEM_D, 64'd0, 0, 0, got);
    pulse_inval();
    run_req(M_XSC, 40'h0080000010, MEM_D, 64'd7, 0, 0, got);
    check("sc_after_inval", got, 64'd1);
    run_req(M_XLR, 40'h0080000010, MEM_D, 64'd0, 0, 0, got);
    run_req(M_XSC, 40'h0080000010, MEM_D, 64'd6, 0, 1, got);
    check("sc_inval_same_cycle", got, 64'd1);

    run_req(M_XWR, 40'h0080000018, MEM_D, 64'hAAAAAAAAAAAAAAAA, 1, 0, got);
    run_req(M_XRD, 40'h0080000018, MEM_D, 64'd0, 0, 0, got);
    run_req(5'b01000, 40'h0080000020, MEM_D, 64'd0, 0, 0, got);

    reset_mid_load(40'h0080000020);

    for (int n = 0; n < 400; n++) begin
      int r, r2, sz, off, w;
      logic [4:0]  c;
      logic [2:0]  o;
      logic [39:0] a;
      bit k, iv;
      r = $urandom_range(0, 99);
      if (r < 35)      c = M_XRD;
      else if (r < 65) c = M_XWR;
      else if (r < 77) c = M_XLR;
      else if (r < 92) c = M_XSC;
      else             c = 5'($urandom_range(8, 31));
      if (c == M_XRD)                      o = 3'($urandom_range(0, 6));
      else if (c == M_XWR)                 o = 3'($urandom_range(0, 3));
      else if (c == M_XLR || c == M_XSC)   o = 3'($urandom_range(2, 3));
      else                                 o = 3'($urandom_range(0, 7));
      sz = size_bytes(o);
      w  = $urandom_range(0, WIN_WORDS - 1);
      r2 = $urandom_range(0, 99);
      if (c == M_XSC && have_lr && r2 < 60) begin
        a = last_lr;
      end else if (r2 < 85) begin
        off = ($urandom_range(0, 7) / sz) * sz;
        a = BASE + 40'(8*w) + 40'(off);
      end else if (r2 < 93) begin
        a = BASE + 40'(8*w) + 40'($urandom_range(0, 7));
      end else if ($urandom_range(0, 1) == 1) begin
        a = BASE - 40'(8 * $urandom_range(1, 4));
      end else begin
        a = BASE + 40'(8*DEPTH) + 40'(8 * $urandom_range(0, 4));
      end
      k  = ($urandom_range(0, 9) == 0);
      iv = (c != M_XLR) && ($urandom_range(0, 9) == 0);
      if (c == M_XLR) begin
        last_lr = a;
        have_lr = 1;
      end
      run_req(c, a, o, {$urandom, $urandom}, k, iv, got);
      if ($urandom_range(0, 19) == 0) pulse_inval();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
